pq_ingress: RTL and testbench

Upstream front-end for the `pq` priority queue. Accepts tagged insert requests and cancel requests from up to `TAGS` requesters over valid/ready handshakes. Drives the queue's push and drop handshakes and records the queue-assigned entry ID per tag, so requesters cancel by their own tag instead of by queue ID. A downstream retire report frees a tag once its entry has been popped.

---
 rtl/pq_ingress.sv | 165 ++++++++++++++++
 tb/tb_pq_ingress.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_ingress.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pq_ingress
//  Purpose  : Front-end for the pq priority queue. It accepts tagged insert
//             and cancel requests, drives the queue push/drop handshakes,
//             and remembers the queue-assigned entry ID for each tag. This
//             lets requesters cancel by their own tag. Retire reports free
//             tags whose entries were popped.
//  Ports    : clk_i, rst_i              clock, synchronous active-high reset
//             req_*                     insert request (valid/ready, data, tag)
//             cancel_*                  cancel request, done/miss pulses
//             pq_push_*, pq_data_o      push handshake toward the queue
//             pq_drop_*                 drop handshake toward the queue
//             pq_full_i                 queue full indication
//             retire_valid_i/retire_id_i pop report from the queue
//             tag_live_o                per-tag "owns a queued entry" mask
//  Revision : 1.0  initial release
// ============================================================================
module pq_ingress #(
  parameter int DW   = 8,
  parameter int IDW  = 4,
  parameter int TAGS = 4,
  parameter int TW   = $clog2(TAGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [DW-1:0]   req_data_i,
  input  logic [TW-1:0]   req_tag_i,
  input  logic            cancel_valid_i,
  output logic            cancel_ready_o,
  input  logic [TW-1:0]   cancel_tag_i,
  output logic            cancel_done_o,
  output logic            cancel_miss_o,
  output logic            pq_push_o,
  output logic [DW-1:0]   pq_data_o,
  input  logic            pq_push_rdy_i,
  input  logic [IDW-1:0]  pq_push_id_i,
  input  logic            pq_full_i,
  output logic            pq_drop_o,
  output logic [IDW-1:0]  pq_drop_id_o,
  input  logic            pq_drop_rdy_i,
  input  logic            retire_valid_i,
  input  logic [IDW-1:0]  retire_id_i,
  output logic [TAGS-1:0] tag_live_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PUSH = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          r_state;
  logic [TAGS-1:0] r_live;
  logic [IDW-1:0]  r_table [TAGS];
  logic [DW-1:0]   r_data;
  logic [TW-1:0]   r_tag;
  logic            r_done;
  logic            r_miss;

  logic [TAGS-1:0] w_hit;
  logic [TAGS-1:0] w_live_eff;
  logic [TAGS-1:0] w_live_next;
  logic            w_idle;
  logic            w_req_fire;
  logic            w_cancel_fire;

  // A retire report frees every live tag whose recorded ID matches it.
  for (genvar t = 0; t < TAGS; t++) begin : g_hit
    assign w_hit[t] = retire_valid_i & r_live[t] & (r_table[t] == retire_id_i);
  end

  // Liveness after this cycle's retire. A cancel that races a retire of the
  // same tag sees the tag as already gone, so it misses instead of dropping
  // an entry that has just left the queue.
  assign w_live_eff = r_live & ~w_hit;

  assign w_idle         = (r_state == S_IDLE);
  assign cancel_ready_o = w_idle & ~rst_i;
  assign req_ready_o    = w_idle & ~rst_i & ~cancel_valid_i & ~pq_full_i
                          & ~r_live[req_tag_i];
  assign w_req_fire     = req_valid_i & req_ready_o;
  assign w_cancel_fire  = cancel_valid_i & cancel_ready_o;

  assign pq_push_o     = (r_state == S_PUSH);
  assign pq_data_o     = pq_push_o ? r_data : '0;
  assign pq_drop_o     = (r_state == S_DROP);
  // The table entry for the held tag is only written on a push completion,
  // which cannot happen while in DROP, so the drop ID is stable.
  assign pq_drop_id_o  = pq_drop_o ? r_table[r_tag] : '0;
  assign cancel_done_o = r_done;
  assign cancel_miss_o = r_miss;
  assign tag_live_o    = r_live;

  // A push completing in the same cycle as a retire keeps its new entry live
  // even if the retired ID equals the freshly assigned one.
  always_comb begin
    w_live_next = w_live_eff;
    if (r_state == S_PUSH && pq_push_rdy_i) begin
      w_live_next[r_tag] = 1'b1;
    end
    if (r_state == S_DROP && pq_drop_rdy_i) begin
      w_live_next[r_tag] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_live  <= '0;
      r_data  <= '0;
      r_tag   <= '0;
      r_done  <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_live <= w_live_next;
      r_done <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cancel_fire) begin
            if (w_live_eff[cancel_tag_i]) begin
              r_tag   <= cancel_tag_i;
              r_state <= S_DROP;
            end else begin
              r_miss <= 1'b1;
            end
          end else if (w_req_fire) begin
            r_data  <= req_data_i;
            r_tag   <= req_tag_i;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (pq_push_rdy_i) begin
            r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (pq_drop_rdy_i) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_hit[r_tag]) begin
            // Entry popped before the queue took the drop: nothing to drop.
            r_miss  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ID table has no reset; entries are only meaningful while live is set.
  always_ff @(posedge clk_i) begin
    if (!rst_i && r_state == S_PUSH && pq_push_rdy_i) begin
      r_table[r_tag] <= pq_push_id_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pq_ingress.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pq_ingress
//  Purpose  : Self-checking bench for pq_ingress. A behavioural model tracks
//             the outstanding operation and per-tag ownership; a compare
//             process checks every DUT output against it on each falling
//             edge. Directed scenarios pin the model with literal values,
//             then randomized traffic exercises the races.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pq_ingress;
  localparam int DW   = 8;
  localparam int IDW  = 4;
  localparam int TAGS = 4;
  localparam int TW   = 2;
  localparam int OP_NONE = 0;
  localparam int OP_PUSH = 1;
  localparam int OP_DROP = 2;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [DW-1:0]   req_data;
  logic [TW-1:0]   req_tag;
  logic            cancel_valid;
  logic            cancel_ready;
  logic [TW-1:0]   cancel_tag;
  logic            cancel_done;
  logic            cancel_miss;
  logic            pq_push;
  logic [DW-1:0]   pq_data;
  logic            push_rdy;
  logic [IDW-1:0]  push_id;
  logic            pq_full;
  logic            pq_drop;
  logic [IDW-1:0]  drop_id;
  logic            drop_rdy;
  logic            retire_valid;
  logic [IDW-1:0]  retire_id;
  logic [TAGS-1:0] tag_live;

  pq_ingress #(.DW(DW), .IDW(IDW), .TAGS(TAGS), .TW(TW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_data_i     (req_data),
    .req_tag_i      (req_tag),
    .cancel_valid_i (cancel_valid),
    .cancel_ready_o (cancel_ready),
    .cancel_tag_i   (cancel_tag),
    .cancel_done_o  (cancel_done),
    .cancel_miss_o  (cancel_miss),
    .pq_push_o      (pq_push),
    .pq_data_o      (pq_data),
    .pq_push_rdy_i  (push_rdy),
    .pq_push_id_i   (push_id),
    .pq_full_i      (pq_full),
    .pq_drop_o      (pq_drop),
    .pq_drop_id_o   (drop_id),
    .pq_drop_rdy_i  (drop_rdy),
    .retire_valid_i (retire_valid),
    .retire_id_i    (retire_id),
    .tag_live_o     (tag_live)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;
  bit          chk_en;

  // Model: one pending operation plus the owner table.
  int              m_op;
  logic [TW-1:0]   m_tag;
  logic [DW-1:0]   m_data;
  logic [TAGS-1:0] m_live;
  logic [IDW-1:0]  m_id [TAGS];
  bit              m_done;
  bit              m_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies the rules of one clock edge to the model, using the inputs
  // held across that edge.
  task automatic model_step();
    logic [TAGS-1:0] popped;
    logic [TAGS-1:0] owned;
    if (rst) begin
      m_op = OP_NONE; m_live = '0; m_done = 0; m_miss = 0;
      return;
    end
    for (int t = 0; t < TAGS; t++)
      popped[t] = retire_valid && m_live[t] && (m_id[t] == retire_id);
    owned  = m_live & ~popped;
    m_done = 0;
    m_miss = 0;
    if (m_op == OP_NONE) begin
      if (cancel_valid) begin
        if (owned[cancel_tag]) begin m_op = OP_DROP; m_tag = cancel_tag; end
        else m_miss = 1;
      end else if (req_valid && !pq_full && !m_live[req_tag]) begin
        m_op = OP_PUSH; m_tag = req_tag; m_data = req_data;
      end
    end else if (m_op == OP_PUSH) begin
      if (push_rdy) begin
        m_id[m_tag] = push_id; owned[m_tag] = 1'b1; m_op = OP_NONE;
      end
    end else begin
      if (drop_rdy) begin
        owned[m_tag] = 1'b0; m_done = 1; m_op = OP_NONE;
      end else if (popped[m_tag]) begin
        m_miss = 1; m_op = OP_NONE;
      end
    end
    m_live = owned;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_rr;
      bit exp_cr;
      exp_cr = !rst && (m_op == OP_NONE);
      exp_rr = exp_cr && !cancel_valid && !pq_full && !m_live[req_tag];
      chk("req_ready",    32'(req_ready),    32'(exp_rr));
      chk("cancel_ready", 32'(cancel_ready), 32'(exp_cr));
      chk("pq_push",      32'(pq_push),      32'(m_op == OP_PUSH));
      chk("pq_data",      32'(pq_data),      (m_op == OP_PUSH) ? 32'(m_data) : 32'd0);
      chk("pq_drop",      32'(pq_drop),      32'(m_op == OP_DROP));
      chk("pq_drop_id",   32'(drop_id),      (m_op == OP_DROP) ? 32'(m_id[m_tag]) : 32'd0);
      chk("cancel_done",  32'(cancel_done),  32'(m_done));
      chk("cancel_miss",  32'(cancel_miss),  32'(m_miss));
      chk("tag_live",     32'(tag_live),     32'(m_live));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; chk_en = 0;
    m_op = OP_NONE; m_tag = '0; m_data = '0; m_live = '0; m_done = 0; m_miss = 0;
    for (int t = 0; t < TAGS; t++) m_id[t] = '0;
    rst = 1; req_valid = 0; req_data = '0; req_tag = '0;
    cancel_valid = 0; cancel_tag = '0; push_rdy = 0; push_id = '0;
    pq_full = 0; drop_rdy = 0; retire_valid = 0; retire_id = '0;

    tick();
    chk_en = 1;
    #1;
    chk("rst_cancel_ready", 32'(cancel_ready), 32'd0);
    chk("rst_tag_live",     32'(tag_live),     32'd0);
    tick();
    rst = 0;
    #1;
    chk("idle_cancel_ready", 32'(cancel_ready), 32'd1);

    // Insert tag 1 / 0x15, queue returns ID 3, then cancel tag 1.
    req_valid = 1; req_tag = 2'd1; req_data = 8'h15;
    #1 chk("ins_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 0; push_rdy = 1; push_id = 4'd3;
    #1 chk("ins_push", 32'(pq_push), 32'd1);
    chk("ins_data", 32'(pq_data), 32'h15);
    tick();
    push_rdy = 0;
    #1 chk("ins_live", 32'(tag_live), 32'b0010);
    cancel_valid = 1; cancel_tag = 2'd1;
    tick();
    cancel_valid = 0;
    #1 chk("cxl_drop", 32'(pq_drop), 32'd1);
    chk("cxl_drop_id", 32'(drop_id), 32'd3);
    drop_rdy = 1;
    tick();
    drop_rdy = 0;
    #1 chk("cxl_done", 32'(cancel_done), 32'd1);
    chk("cxl_live", 32'(tag_live), 32'b0000);
    tick();
    #1 chk("cxl_done_once", 32'(cancel_done), 32'd0);

    // Cancel of a tag that owns nothing.
    cancel_valid = 1; cancel_tag = 2'd2;
    tick();
    cancel_valid = 0;
    #1 chk("miss_pulse", 32'(cancel_miss), 32'd1);
    chk("miss_nodrop", 32'(pq_drop), 32'd0);
    tick();

    // Push backpressure: data held, ID taken only on the rdy cycle.
    req_valid = 1; req_tag = 2'd0; req_data = 8'hF0;
    tick();
    req_valid = 0; push_rdy = 0; push_id = 4'd9;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_push", 32'(pq_push), 32'd1);
      chk("bp_data", 32'(pq_data), 32'hF0);
      tick();
    end
    push_rdy = 1; push_id = 4'd5;
    tick();
    push_rdy = 0;
    #1 chk("bp_live", 32'(tag_live), 32'b0001);

    // Insert on live tag 0 stalls until ID 5 retires.
    req_valid = 1; req_tag = 2'd0; req_data = 8'h22;
    #1 chk("stall_ready", 32'(req_ready), 32'd0);
    tick();
    retire_valid = 1; retire_id = 4'd5;
    #1 chk("stall_ready_ret", 32'(req_ready), 32'd0);
    tick();
    retire_valid = 0;
    #1 chk("stall_freed", 32'(tag_live), 32'd0);
    chk("stall_ready_free", 32'(req_ready), 32'd1);
    tick();
    req_valid = 0; push_rdy = 1; push_id = 4'd7;
    #1 chk("stall_data", 32'(pq_data), 32'h22);
    tick();
    push_rdy = 0;

    // Insert and cancel together: cancel wins; then retire races the drop.
    req_valid = 1; req_tag = 2'd2; req_data = 8'h33;
    cancel_valid = 1; cancel_tag = 2'd0;
    #1 chk("prio_req_ready", 32'(req_ready), 32'd0);
    chk("prio_cxl_ready", 32'(cancel_ready), 32'd1);
    tick();
    req_valid = 0; cancel_valid = 0;
    retire_valid = 1; retire_id = 4'd7; drop_rdy = 0;
    #1 chk("prio_drop", 32'(pq_drop), 32'd1);
    chk("prio_drop_id", 32'(drop_id), 32'd7);
    chk("prio_nopush", 32'(pq_push), 32'd0);
    tick();
    retire_valid = 0;
    #1 chk("race_miss", 32'(cancel_miss), 32'd1);
    chk("race_done", 32'(cancel_done), 32'd0);
    chk("race_drop_fell", 32'(pq_drop), 32'd0);
    chk("race_live", 32'(tag_live), 32'd0);
    tick();

    // Queue full blocks inserts.
    pq_full = 1; req_valid = 1; req_tag = 2'd3;
    #1 chk("full_ready", 32'(req_ready), 32'd0);
    tick();
    pq_full = 0; req_valid = 0;
    #1 chk("full_nopush", 32'(pq_push), 32'd0);

    // Give tag 2 an entry, then reset in the middle of a push for tag 3.
    req_valid = 1; req_tag = 2'd2; req_data = 8'h55;
    tick();
    req_valid = 0; push_rdy = 1; push_id = 4'd9;
    tick();
    push_rdy = 0;
    #1 chk("pre_rst_live", 32'(tag_live), 32'b0100);
    req_valid = 1; req_tag = 2'd3; req_data = 8'h44;
    tick();
    req_valid = 0;
    #1 chk("mid_push", 32'(pq_push), 32'd1);
    rst = 1;
    #1 chk("rst_hi_cancel_ready", 32'(cancel_ready), 32'd0);
    tick();
    rst = 0;
    #1 chk("rst_push", 32'(pq_push), 32'd0);
    chk("rst_data", 32'(pq_data), 32'd0);
    chk("rst_live", 32'(tag_live), 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst          = ($urandom_range(199) == 0);
      req_valid    = $urandom_range(1) == 1;
      req_tag      = TW'($urandom);
      req_data     = DW'($urandom);
      cancel_valid = ($urandom_range(4) == 0);
      cancel_tag   = TW'($urandom);
      pq_full      = ($urandom_range(5) == 0);
      push_rdy     = !pq_full && ($urandom_range(2) != 0);
      push_id      = IDW'($urandom);
      drop_rdy     = ($urandom_range(2) == 0);
      retire_valid = ($urandom_range(3) == 0);
      if ($urandom_range(1) == 1) retire_id = m_id[$urandom_range(TAGS-1)];
      else                        retire_id = IDW'($urandom);
    end
    tick();
    rst = 0; req_valid = 0; cancel_valid = 0; retire_valid = 0;
    tick();
    tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
